// File: rtl/lpc_uart_tx.sv
// LPC-UART transmit path: host bytes are queued in a small FIFO and shifted out on uart_tx
// as 8N1 frames, LSB first, with back-to-back frames when more data is waiting.
module lpc_uart_tx #(
  parameter int CLKS_PER_BIT = 286,
  parameter int FIFO_AW      = 4
) (
  input  logic               lpc_clk,
  input  logic               lpc_rst,
  input  logic               wr_en,
  input  logic [7:0]         wr_data,
  input  logic               clr_overrun,
  output logic               uart_tx,
  output logic               fifo_full,
  output logic               fifo_empty,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               busy,
  output logic               overrun
);

  localparam int                 DEPTH    = 2 ** FIFO_AW;
  localparam int                 TW       = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0]      T_LAST   = TW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0]   LVL_FULL = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [2:0]          idx_q, idx_d;
  logic [7:0]          shift_q, shift_d;

  logic [7:0]          mem [DEPTH];
  logic [FIFO_AW-1:0]  rd_ptr, wr_ptr;
  logic [FIFO_AW:0]    level_d;

  logic                pop;
  logic                push;
  logic                drop;
  logic                bit_end;
  logic                tx_bit;

  assign bit_end = (timer_q == T_LAST);
  assign busy    = (state_q != IDLE);

  // A full FIFO still accepts a write on the cycle the FSM pops, since a slot frees up.
  assign push = wr_en && (!fifo_full || pop);
  assign drop = wr_en && fifo_full && !pop;

  always_comb begin
    level_d = fifo_level;
    case ({push, pop})
      2'b10:   level_d = fifo_level + 1'b1;
      2'b01:   level_d = fifo_level - 1'b1;
      default: level_d = fifo_level;
    endcase
  end

  always_ff @(posedge lpc_clk) begin
    if (lpc_rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_level <= '0;
      fifo_full  <= 1'b0;
      fifo_empty <= 1'b1;
      overrun    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= level_d;
      fifo_full  <= (level_d == LVL_FULL);
      fifo_empty <= (level_d == '0);
      if (drop)             overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

  always_ff @(posedge lpc_clk) begin
    if (push && !lpc_rst) mem[wr_ptr] <= wr_data;
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr];
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          timer_d = '0;
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          timer_d = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          timer_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge lpc_clk) begin
    if (lpc_rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge lpc_clk) begin
    shift_q <= shift_d;
  end

  // Line level is registered from the current state, so it trails the FSM by one cycle.
  always_comb begin
    tx_bit = 1'b1;
    case (state_q)
      START:   tx_bit = 1'b0;
      DATA:    tx_bit = shift_q[0];
      default: tx_bit = 1'b1;
    endcase
  end

  always_ff @(posedge lpc_clk) begin
    if (lpc_rst) uart_tx <= 1'b1;
    else         uart_tx <= tx_bit;
  end

endmodule

// File: tb/tb_lpc_uart_tx.sv
// Bench for lpc_uart_tx: frame-level reference model compared every cycle, plus directed
// scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_lpc_uart_tx;

  localparam int C     = 286;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int FRAME = 10 * C;

  logic          clk = 1'b0;
  logic          lpc_rst;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          clr_overrun;
  logic          uart_tx;
  logic          fifo_full;
  logic          fifo_empty;
  logic [AW:0]   fifo_level;
  logic          busy;
  logic          overrun;

  int n_vec = 0;
  int n_bad = 0;

  lpc_uart_tx #(.CLKS_PER_BIT(C), .FIFO_AW(AW)) dut (
    .lpc_clk     (clk),
    .lpc_rst     (lpc_rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .clr_overrun (clr_overrun),
    .uart_tx     (uart_tx),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .fifo_level  (fifo_level),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of bytes and one counter over the 10-bit frame.
  logic [7:0] q[$];
  bit         m_active = 1'b0;
  int         m_cnt    = 0;
  logic [7:0] m_cur    = '0;
  logic       m_tx     = 1'b1;
  logic       m_ovr    = 1'b0;
  bit         chk_en   = 1'b0;
  int         m_b;
  bit         m_pop, m_fe, m_drop;

  always @(posedge clk) begin
    if (lpc_rst) begin
      q.delete();
      m_active = 1'b0;
      m_cnt    = 0;
      m_tx     = 1'b1;
      m_ovr    = 1'b0;
      chk_en   = 1'b1;
    end else begin
      m_b  = m_cnt / C;
      m_tx = !m_active ? 1'b1 : (m_b == 0 ? 1'b0 : (m_b == 9 ? 1'b1 : m_cur[m_b-1]));
      m_fe  = m_active && (m_cnt == FRAME - 1);
      m_pop = (q.size() != 0) && (!m_active || m_fe);
      if (m_active) begin
        if (m_fe) m_active = 1'b0;
        else      m_cnt++;
      end
      if (m_pop) begin
        m_cur    = q.pop_front();
        m_active = 1'b1;
        m_cnt    = 0;
      end
      m_drop = 1'b0;
      if (wr_en) begin
        if (q.size() < DEPTH) q.push_back(wr_data);
        else                  m_drop = 1'b1;
      end
      if (m_drop)           m_ovr = 1'b1;
      else if (clr_overrun) m_ovr = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("uart_tx",    uart_tx,    m_tx);
      check("busy",       busy,       m_active);
      check("fifo_empty", fifo_empty, q.size() == 0);
      check("fifo_full",  fifo_full,  q.size() == DEPTH);
      check("fifo_level", fifo_level, q.size());
      check("overrun",    overrun,    m_ovr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic count_busy(input int bound, output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < bound) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    bit exp_bits[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int n;
    int lows;

    lpc_rst = 1'b1; wr_en = 1'b0; wr_data = '0; clr_overrun = 1'b0;
    ticks(2);
    lpc_rst = 1'b0;
    ticks(10);

    // Idle after reset
    check("t1_tx",    uart_tx,    1);
    check("t1_busy",  busy,       0);
    check("t1_empty", fifo_empty, 1);
    check("t1_level", fifo_level, 0);
    check("t1_ovr",   overrun,    0);

    // Single frame of 0x0f
    wr(8'h0f);
    check("t2_empty_n",  fifo_empty, 0);
    check("t2_busy_n",   busy,       0);
    tick();
    check("t2_tx_n1",    uart_tx,    1);
    check("t2_busy_n1",  busy,       1);
    tick();
    check("t2_tx_n2",    uart_tx,    0);
    for (int k = 0; k < 10; k++) begin
      ticks(C / 2);
      check($sformatf("t2_bit%0d", k), uart_tx, exp_bits[k]);
      ticks(C - C / 2);
    end
    check("t2_busy_end", busy,    0);
    check("t2_tx_end",   uart_tx, 1);
    ticks(3);

    // Two frames back-to-back
    wr(8'ha5);
    wr(8'hf0);
    count_busy(30000, n);
    check("t3_busy_len", n, 2 * FRAME);
    ticks(3);

    // Overfill the FIFO while a frame is in progress
    wr(8'h11);
    tick();
    for (int i = 0; i < 17; i++) begin
      wr(8'(8'hf0 + i));
      if (i == 15) begin
        check("t4_full16",  fifo_full,  1);
        check("t4_level16", fifo_level, 16);
        check("t4_ovr16",   overrun,    0);
      end
    end
    check("t4_ovr17",   overrun,    1);
    check("t4_level17", fifo_level, 16);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    check("t4_ovr_clr", overrun, 0);

    // Write on the cycle the stop bit ends while full
    n = 0;
    while (!(m_active && m_cnt == FRAME - 1) && n < 5000) begin
      tick();
      n++;
    end
    check("t5_reach",      n < 5000,   1);
    check("t5_level_pre",  fifo_level, 16);
    wr_en = 1'b1; wr_data = 8'haa;
    tick();
    wr_en = 1'b0;
    check("t5_level_post", fifo_level, 16);
    check("t5_full_post",  fifo_full,  1);
    check("t5_ovr_post",   overrun,    0);
    n = 0;
    while (!(busy === 1'b0 && fifo_empty === 1'b1) && n < 60000) begin
      tick();
      n++;
    end
    check("t5_drain", n < 60000, 1);
    check("t5_ovr_end", overrun, 0);
    ticks(3);

    // Reset mid-frame with bytes queued
    wr(8'hf3);
    wr(8'h01);
    wr(8'h02);
    wr(8'h03);
    ticks(2 * C);
    check("t6_busy_pre",  busy,       1);
    check("t6_level_pre", fifo_level, 3);
    lpc_rst = 1'b1;
    tick();
    lpc_rst = 1'b0;
    check("t6_tx_rst",    uart_tx,    1);
    check("t6_empty_rst", fifo_empty, 1);
    check("t6_level_rst", fifo_level, 0);
    check("t6_busy_rst",  busy,       0);
    lows = 0;
    repeat (FRAME) begin
      tick();
      if (uart_tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    check("t6_quiet", lows, 0);
    wr(8'hf4);
    check("t6_busy_n", busy, 0);
    tick();
    count_busy(5000, n);
    check("t6_frame_len", n, FRAME);
    ticks(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
